// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding and load-use hazard unit with its own MEM/WB write-descriptor shadow slots.
// Optional FWD_STATS_EN macro adds saturating forward/stall cycle counters.
module fwd_hazard_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ex_valid_i,
    input  logic [ADDR_W-1:0]           ex_rd_i,
    input  logic                        ex_regwrite_i,
    input  logic                        ex_memread_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_rs_i,
    input  logic [NUM_SRC*DATA_W-1:0]   ex_rf_data_i,
    input  logic [DATA_W-1:0]           mem_alu_result_i,
    input  logic [DATA_W-1:0]           wb_write_data_i,
    input  logic                        flush_i,
    output logic [NUM_SRC*DATA_W-1:0]   ex_opnd_o,
    output logic [NUM_SRC*2-1:0]        fwd_sel_o,
`ifdef FWD_STATS_EN
    input  logic                        stat_clr_i,
    output logic [15:0]                 stat_fwd_o,
    output logic [15:0]                 stat_stall_o,
`endif
    output logic                        stall_o
);

    logic              mem_v_q, mem_rw_q, mem_ld_q;
    logic [ADDR_W-1:0] mem_rd_q;
    logic              wb_v_q, wb_rw_q;
    logic [ADDR_W-1:0] wb_rd_q;
    logic              mem_v_d;

    logic [NUM_SRC-1:0] mem_hit;
    logic [NUM_SRC-1:0] wb_hit;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        mem_hit   = '0;
        wb_hit    = '0;
        fwd_sel_o = '0;
        ex_opnd_o = ex_rf_data_i;
        for (int k = 0; k < NUM_SRC; k++) begin
            mem_hit[k] = mem_v_q & mem_rw_q & (mem_rd_q != '0)
                       & (mem_rd_q == ex_rs_i[k*ADDR_W +: ADDR_W]);
            wb_hit[k]  = wb_v_q & wb_rw_q & (wb_rd_q != '0)
                       & (wb_rd_q == ex_rs_i[k*ADDR_W +: ADDR_W]);
            // A load still in MEM has no data yet; fall back to WB (or the register file).
            if (mem_hit[k] && !mem_ld_q) begin
                fwd_sel_o[k*2 +: 2]           = 2'b10;
                ex_opnd_o[k*DATA_W +: DATA_W] = mem_alu_result_i;
            end else if (wb_hit[k]) begin
                fwd_sel_o[k*2 +: 2]           = 2'b01;
                ex_opnd_o[k*DATA_W +: DATA_W] = wb_write_data_i;
            end
        end
    end

    assign stall_o = ex_valid_i & ~flush_i & mem_ld_q & (|mem_hit);
    assign mem_v_d = ex_valid_i & ~stall_o & ~flush_i;

    // NOTE: sequential state uses non-blocking assignments so WB samples the old MEM slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            mem_ld_q <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
        end else begin
            wb_v_q   <= mem_v_q;
            wb_rd_q  <= mem_rd_q;
            wb_rw_q  <= mem_rw_q;
            mem_v_q  <= mem_v_d;
            mem_rd_q <= ex_rd_i;
            mem_rw_q <= ex_regwrite_i;
            mem_ld_q <= ex_memread_i;
        end
    end

`ifdef FWD_STATS_EN
    logic [15:0] stat_fwd_q, stat_fwd_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_fwd_d   = stat_fwd_q;
        stat_stall_d = stat_stall_q;
        if (stat_clr_i) begin
            stat_fwd_d   = '0;
            stat_stall_d = '0;
        end else begin
            if ((|fwd_sel_o) && !stall_o && (stat_fwd_q != 16'hFFFF))
                stat_fwd_d = stat_fwd_q + 16'd1;
            if (stall_o && (stat_stall_q != 16'hFFFF))
                stat_stall_d = stat_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_fwd_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_fwd_q   <= stat_fwd_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_fwd_o   = stat_fwd_q;
    assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed test-plan sequences plus random traffic,
// compared every cycle against a history-of-issued-instructions model.
module tb_fwd_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              ex_valid_i;
    logic [AW-1:0]     ex_rd_i;
    logic              ex_regwrite_i;
    logic              ex_memread_i;
    logic [NS*AW-1:0]  ex_rs_i;
    logic [NS*DW-1:0]  ex_rf_data_i;
    logic [DW-1:0]     mem_alu_result_i;
    logic [DW-1:0]     wb_write_data_i;
    logic              flush_i;
    logic [NS*DW-1:0]  ex_opnd_o;
    logic [NS*2-1:0]   fwd_sel_o;
    logic              stall_o;
`ifdef FWD_STATS_EN
    logic              stat_clr_i;
    logic [15:0]       stat_fwd_o;
    logic [15:0]       stat_stall_o;
    int unsigned       exp_fwd_cnt;
    int unsigned       exp_stall_cnt;
`endif

    fwd_hazard_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ex_valid_i       (ex_valid_i),
        .ex_rd_i          (ex_rd_i),
        .ex_regwrite_i    (ex_regwrite_i),
        .ex_memread_i     (ex_memread_i),
        .ex_rs_i          (ex_rs_i),
        .ex_rf_data_i     (ex_rf_data_i),
        .mem_alu_result_i (mem_alu_result_i),
        .wb_write_data_i  (wb_write_data_i),
        .flush_i          (flush_i),
        .ex_opnd_o        (ex_opnd_o),
        .fwd_sel_o        (fwd_sel_o),
`ifdef FWD_STATS_EN
        .stat_clr_i       (stat_clr_i),
        .stat_fwd_o       (stat_fwd_o),
        .stat_stall_o     (stat_stall_o),
`endif
        .stall_o          (stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Instructions that actually left EX, newest first: [0] is in MEM, [1] is in WB.
    typedef struct {
        bit            v;
        logic [AW-1:0] rd;
        bit            rw;
        bit            ld;
    } desc_t;

    desc_t            hist[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic             exp_stall;
    logic [NS*2-1:0]  exp_sel;
    logic [NS*DW-1:0] exp_opnd;

    function automatic bit produces(desc_t d, logic [AW-1:0] rs);
        return d.v && d.rw && (d.rd != 0) && (d.rd == rs);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        desc_t b;
        b = '{v: 1'b0, rd: '0, rw: 1'b0, ld: 1'b0};
        hist = {};
        hist.push_back(b);
        hist.push_back(b);
`ifdef FWD_STATS_EN
        exp_fwd_cnt   = 0;
        exp_stall_cnt = 0;
`endif
    endtask

    // The newest writer of rs wins; a load that is newest cannot supply data and stalls a real EX.
    task automatic model_eval();
        logic [AW-1:0] rs;
        logic [1:0]    s;
        exp_stall = 1'b0;
        exp_sel   = '0;
        exp_opnd  = ex_rf_data_i;
        for (int k = 0; k < NS; k++) begin
            rs = ex_rs_i[k*AW +: AW];
            s  = 2'b00;
            if (produces(hist[0], rs) && !hist[0].ld) s = 2'b10;
            else if (produces(hist[1], rs))           s = 2'b01;
            if (produces(hist[0], rs) && hist[0].ld && ex_valid_i && !flush_i) exp_stall = 1'b1;
            exp_sel[k*2 +: 2] = s;
            if (s == 2'b10)      exp_opnd[k*DW +: DW] = mem_alu_result_i;
            else if (s == 2'b01) exp_opnd[k*DW +: DW] = wb_write_data_i;
        end
    endtask

    task automatic compare_now();
        model_eval();
        check("stall", 64'(stall_o), 64'(exp_stall));
        check("fwd_sel", 64'(fwd_sel_o), 64'(exp_sel));
        check("ex_opnd", 64'(ex_opnd_o), 64'(exp_opnd));
`ifdef FWD_STATS_EN
        check("stat_fwd", 64'(stat_fwd_o), 64'(exp_fwd_cnt));
        check("stat_stall", 64'(stat_stall_o), 64'(exp_stall_cnt));
`endif
    endtask

    task automatic settle();
        #2;
        compare_now();
    endtask

    task automatic tick();
        desc_t d;
        d.v  = ex_valid_i && !exp_stall && !flush_i;
        d.rd = ex_rd_i;
        d.rw = ex_regwrite_i;
        d.ld = ex_memread_i;
`ifdef FWD_STATS_EN
        if (stat_clr_i) begin
            exp_fwd_cnt   = 0;
            exp_stall_cnt = 0;
        end else begin
            if (exp_sel != 0 && !exp_stall && exp_fwd_cnt < 16'hFFFF) exp_fwd_cnt++;
            if (exp_stall && exp_stall_cnt < 16'hFFFF) exp_stall_cnt++;
        end
`endif
        @(posedge clk_i);
        hist.push_front(d);
        void'(hist.pop_back());
        #1;
    endtask

    task automatic set_ex(bit v, logic [AW-1:0] rd, bit rw, bit ld,
                          logic [AW-1:0] rs0, logic [AW-1:0] rs1, bit fl);
        ex_valid_i    = v;
        ex_rd_i       = rd;
        ex_regwrite_i = rw;
        ex_memread_i  = ld;
        ex_rs_i       = {rs1, rs0};
        flush_i       = fl;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            set_ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
            settle();
            tick();
        end
    endtask

    initial begin
        logic [NS*DW-1:0] rf_snap;
        bit               held;
        rst_i            = 1'b1;
        ex_rf_data_i     = {32'h2222_2222, 32'h1111_1111};
        mem_alu_result_i = 32'h0;
        wb_write_data_i  = 32'h0;
`ifdef FWD_STATS_EN
        stat_clr_i = 1'b0;
`endif
        set_ex(1'b1, 5'd4, 1'b1, 1'b1, 5'd4, 5'd4, 1'b0);
        #22;
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_sel", 64'(fwd_sel_o), 64'd0);
        check("reset_opnd", 64'(ex_opnd_o), 64'({32'h2222_2222, 32'h1111_1111}));
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_clear();

        // EX-to-EX forward from MEM
        idle(2);
        set_ex(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        settle(); tick();
        set_ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0);
        mem_alu_result_i = 32'h1234;
        settle();
        check("ex2ex_sel0", 64'(fwd_sel_o[1:0]), 64'(2'b10));
        check("ex2ex_opnd0", 64'(ex_opnd_o[DW-1:0]), 64'h1234);
        check("ex2ex_stall", 64'(stall_o), 64'd0);
        tick();

        // MEM beats WB when both wrote x7
        idle(2);
        set_ex(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 1'b0);
        mem_alu_result_i = 32'hBBBB;
        wb_write_data_i  = 32'hAAAA;
        settle();
        check("prio_sel0", 64'(fwd_sel_o[1:0]), 64'(2'b10));
        check("prio_opnd0", 64'(ex_opnd_o[DW-1:0]), 64'hBBBB);
        tick();

        // Only the older instruction wrote x7: WB forward
        idle(2);
        set_ex(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 1'b0);
        settle();
        check("wbfwd_sel0", 64'(fwd_sel_o[1:0]), 64'(2'b01));
        check("wbfwd_opnd0", 64'(ex_opnd_o[DW-1:0]), 64'hAAAA);
        tick();

        // Load-use: one stall, then WB forward, then no stale MEM hit
        idle(1);
`ifdef FWD_STATS_EN
        stat_clr_i = 1'b1;
`endif
        idle(1);
`ifdef FWD_STATS_EN
        stat_clr_i = 1'b0;
`endif
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0);
        wb_write_data_i = 32'hCAFE;
        settle();
        check("lu_stall", 64'(stall_o), 64'd1);
        tick();
        settle();
        check("lu_after_stall", 64'(stall_o), 64'd0);
        check("lu_after_sel0", 64'(fwd_sel_o[1:0]), 64'(2'b01));
        check("lu_after_opnd0", 64'(ex_opnd_o[DW-1:0]), 64'hCAFE);
        tick();
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b0);
        settle();
        check("lu_bubble_sel0", 64'(fwd_sel_o[1:0]), 64'(2'b00));
`ifdef FWD_STATS_EN
        check("lu_stat_stall", 64'(stat_stall_o), 64'd1);
        check("lu_stat_fwd", 64'(stat_fwd_o), 64'd1);
        stat_clr_i = 1'b1;
        tick();
        stat_clr_i = 1'b0;
        settle();
        check("clr_stat_stall", 64'(stat_stall_o), 64'd0);
        check("clr_stat_fwd", 64'(stat_fwd_o), 64'd0);
`endif
        tick();

        // x0 is never forwarded and a load to x0 never stalls
        idle(2);
        set_ex(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        ex_rf_data_i = '0;
        settle();
        check("x0_sel", 64'(fwd_sel_o), 64'd0);
        check("x0_stall", 64'(stall_o), 64'd0);
        tick();

        // Flush during load-use wins and leaves a bubble in MEM
        idle(2);
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1);
        settle();
        check("flush_stall", 64'(stall_o), 64'd0);
        tick();
        set_ex(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0);
        settle();
        check("flush_next_sel0", 64'(fwd_sel_o[1:0]), 64'(2'b01));
        check("flush_next_stall", 64'(stall_o), 64'd0);
        tick();

        // Asynchronous reset in the middle of a stall
        idle(2);
        set_ex(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0); settle(); tick();
        set_ex(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd3, 1'b0);
        rf_snap      = {32'h5A5A_0001, 32'hA5A5_0002};
        ex_rf_data_i = rf_snap;
        settle();
        check("rst_pre_stall", 64'(stall_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_stall", 64'(stall_o), 64'd0);
        check("rst_mid_sel", 64'(fwd_sel_o), 64'd0);
        check("rst_mid_opnd", 64'(ex_opnd_o), 64'(rf_snap));
        rst_i = 1'b0;
        #1;
        model_clear();
        compare_now();
        tick();

        // Random traffic; a stalled instruction is held in EX like the real pipeline does
        held = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!held) begin
                set_ex(($urandom_range(0, 7) != 0), AW'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                       AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 1'b0);
            end
            flush_i          = ($urandom_range(0, 7) == 0);
            ex_rf_data_i     = {$urandom, $urandom};
            mem_alu_result_i = $urandom;
            wb_write_data_i  = $urandom;
`ifdef FWD_STATS_EN
            stat_clr_i = ($urandom_range(0, 49) == 0);
`endif
            settle();
            held = exp_stall;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised EX-stage forwarding and load-use hazard unit for the 5-stage pipeline.
- Serves NUM_SRC operand ports in place of per-operand select muxes.
- Keeps its own MEM/WB write-descriptor shadow pipeline (rd, regwrite, memread), so no external comparator logic is needed.
- Produces forwarded operands, select codes, a one-cycle load-use stall, and bubble insertion.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width
- NUM_SRC, 2, number of EX source operands (1..4)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- ex_valid_i  in  1  EX holds a real instruction
- ex_rd_i  in  ADDR_W  EX destination register
- ex_regwrite_i  in  1  EX instruction writes the register file
- ex_memread_i  in  1  EX instruction is a load
- ex_rs_i  in  NUM_SRC*ADDR_W  EX source addresses; src k at [k*ADDR_W +: ADDR_W]
- ex_rf_data_i  in  NUM_SRC*DATA_W  operands from the ID/EX register
- mem_alu_result_i  in  DATA_W  ALU result currently in MEM
- wb_write_data_i  in  DATA_W  write-back data currently in WB
- flush_i  in  1  squash the EX instruction this cycle
- ex_opnd_o  out  NUM_SRC*DATA_W  forwarded operands
- fwd_sel_o  out  NUM_SRC*2  per-source select: 00 register file, 01 WB, 10 MEM
- stall_o  out  1  hold PC/IF/ID/EX this cycle

Behaviour:
- Shadow slots: MEM slot {v,rd,rw,ld} and WB slot {v,rd,rw}, all registered.
- On rst_i, asynchronously: all slot fields = 0.
  - Outputs after reset: stall_o = 0, fwd_sel_o = 0, ex_opnd_o = ex_rf_data_i.
  - rst_i mid-stall drops stall_o immediately.
- Every rising edge:
  - WB slot <= MEM slot.
  - MEM slot <= EX descriptor, gated by v = ex_valid_i & ~stall_o & ~flush_i.
  - A stalled or flushed cycle therefore inserts a bubble (v = 0) into MEM.
- Match rules, per source k, with rs = ex_rs_i[k]:
  - memhit = MEM.v & MEM.rw & MEM.rd != 0 & MEM.rd == rs.
  - wbhit = WB.v & WB.rw & WB.rd != 0 & WB.rd == rs.
  - sel = memhit & ~MEM.ld ? 10 : wbhit ? 01 : 00.
  - Priority: MEM over WB. Register 0 is never forwarded.
- Load-use: stall_o = ex_valid_i & ~flush_i & OR over k of (memhit_k & MEM.ld).
  - A load in MEM cannot forward. While stalled, that source selects WB if wbhit, else 00.
  - Its value is ignored that cycle.
  - Next cycle the load sits in WB: the EX instruction is unchanged (held externally), sel = 01, and stall_o = 0.
  - Stall duration is exactly one cycle per load-use pair.
- ex_opnd_o and fwd_sel_o are combinational from current slots and inputs; latency 0.
- flush_i and a stall condition in the same cycle: flush wins, stall_o = 0, and a bubble is inserted.
- ex_valid_i = 0: stall_o = 0. Selects are still computed; they are harmless.
- Two sources naming the same register resolve independently and identically.
- A load to x0 never stalls.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, adds:
  - ports stat_fwd_o (out, 16): saturating count of cycles with any sel != 00 and stall_o = 0.
  - ports stat_stall_o (out, 16): saturating count of stall_o cycles.
  - input stat_clr_i (in, 1): synchronous clear of both counters, priority over increment.
- Counters reset to 0 on rst_i and saturate at 16'hFFFF.
- When undefined: ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- EX-to-EX: cycle n EX writes x5 (rw = 1, ld = 0); cycle n+1 EX reads rs0 = 5, mem_alu_result_i = 32'h1234 -> sel0 = 10, opnd0 = 32'h1234, stall_o = 0.
- WB forward with priority:
  - x7 written by instruction A, then x7 by B, then C reads x7; mem = 32'hBBBB, wb = 32'hAAAA -> sel = 10, opnd = 32'hBBBB.
  - With B writing x8 instead -> sel = 01, opnd = 32'hAAAA.
- Load-use: load x3 followed by reader of x3 -> stall_o = 1 for exactly 1 cycle.
  - Next cycle: sel = 01, opnd = wb_write_data_i = 32'hCAFE.
  - MEM slot holds a bubble (no spurious forward on the cycle after).
- x0 rule: writer and load to x0, reader rs = 0, rf data = 32'h0 -> sel = 00, stall_o = 0.
- Flush/reset:
  - flush_i asserted during a load-use condition -> stall_o = 0, and the next cycle shows no MEM hit.
  - rst_i pulsed mid-stall, asynchronously -> stall_o and all sel = 0 before the next edge.
- FWD_STATS_EN: after the load-use sequence -> stat_stall_o = 1 and stat_fwd_o = 1; stat_clr_i -> both 0 next cycle.
